keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans the 4x4 hex keypad matrix and delivers a debounced 16-bit key state to the CPU, one bit per CHIP-8 key value. It drives one column low at a time, samples the active-low rows through a two-flop synchronizer, and applies a per-key debounce. It sits directly upstream of the CPU's `keymap` input and also reports newly pressed keys as a one-cycle event for the Fx0A (wait-for-key) instruction.

## Interface
Parameters:
- `SCAN_DIV`, default 1024: clock cycles each column is driven before its rows are sampled; legal range is 4 or more.
- `DEBOUNCE_SCANS`, default 4: number of consecutive column samples that must disagree with the current state before a key flips; legal range is 1 or more.

Ports:
- `fpga_clk`  in  1: the only clock.
- `rst_in`  in  1: asynchronous, active-low reset.
- `row`  in  4: matrix rows; externally pulled up, so low means pressed; asynchronous to `fpga_clk`.
- `col`  out  4: one-cold column drive; the driven column is 0, all others are 1.
- `keymap`  out  16: debounced state; bit k is 1 when CHIP-8 key k is held.
- `key_event`  out  1: one-cycle pulse when at least one key goes from released to pressed.
- `key_code`  out  4: the CHIP-8 value of the new press; valid while `key_event` is 1 and holds its value otherwise.

## Operation
- Matrix map, listed as row r, columns 0..3:
  - r0: 1, 2, 3, C
  - r1: 4, 5, 6, D
  - r2: 7, 8, 9, E
  - r3: A, 0, B, F
- Column index `c` cycles 0→1→2→3→0. `col = ~(4'b1 << c)`.
- Dwell counter `dc` counts 0..SCAN_DIV-1 while column `c` is driven.
- `row` passes through a two-flop synchronizer to give `row_s`. Raw pressed for key (r, c) = `~row_s[r]`.
- On the sample edge (`dc == SCAN_DIV-1`), each of the 4 keys in column `c` updates its own counter `cnt`, which is `$clog2(DEBOUNCE_SCANS)+1` bits wide:
  - raw equals the `keymap` bit: `cnt <= 0`.
  - raw differs and `cnt == DEBOUNCE_SCANS-1`: the `keymap` bit takes the raw value and `cnt <= 0`.
  - raw differs otherwise: `cnt <= cnt + 1`.
- Keys in columns not being sampled keep both their `keymap` bit and their `cnt`.
- On that same edge, `c` advances and `dc` returns to 0.
- If one or more keys in the sampled column flip from 0 to 1, `key_event` is set and `key_code` takes the lowest CHIP-8 value among those keys. Releases never raise `key_event`.
- Ghosting from three or more simultaneous presses is not corrected; `keymap` reports what the matrix reads.

## Timing
- Reset values:
  - `col = 4'b1110` (c = 0).
  - `dc = 0`, all `cnt = 0`.
  - `keymap = 16'h0000`, `key_event = 0`, `key_code = 4'h0`.
  - Synchronizer flops = `4'hF`.
- Reset asserted mid-scan returns everything to the reset values immediately. `keymap` does not rebuild until after release.
- The first sample edge after reset release is the edge at which `dc == SCAN_DIV-1`, i.e. the `SCAN_DIV`-th rising edge. Full scan period is `4*SCAN_DIV` cycles.
- `keymap`, `key_event`, `key_code` and the new `col` are all registered on the sample edge and become visible in the following cycle.
- `key_event` stays high for exactly 1 cycle. At most one event occurs per `SCAN_DIV` cycles.
- Rows settle for at least `SCAN_DIV-3` cycles after a column change before being sampled, which accounts for the 2-cycle synchronizer.
- Press or release latency: the change becomes visible on the `DEBOUNCE_SCANS`-th sample of that key's column. Worst-case latency from a stable input is `4*SCAN_DIV*DEBOUNCE_SCANS + SCAN_DIV + 2` cycles.
- A bounce that restores the stable value at any sample clears `cnt`, so the key does not flip.
- A key pressed and released within the same dwell period is not seen.

## Test plan
All scenarios use `SCAN_DIV=4` and `DEBOUNCE_SCANS=3`.
1. Reset, `row=4'hF` held for 100 cycles → `col` cycles 1110, 1101, 1011, 0111 with 4 cycles per step; `keymap` stays 0; `key_event` never asserts.
2. Hold row 1 low whenever col 2 is low (key 6) → after the 3rd col-2 sample, `keymap = 16'h0040`, `key_event` pulses once, `key_code = 4'h6`. Release → `keymap` returns to 0 after 3 samples, with no event.
3. Key 6 pressed for 2 samples, released for 1, then pressed again → no flip until 3 consecutive pressed samples; exactly one `key_event`.
4. Keys A (r3,c0) and 7 (r2,c0) pressed together → single event with `key_code = 4'h7`; `keymap = 16'h0480`.
5. Assert `rst_in` low while key F is debounced-pressed and midway through a dwell → `keymap = 0` and `col = 1110` immediately. After release with F still held, F reappears after 3 col-3 samples.
6. `DEBOUNCE_SCANS=1`: press 0 (r3,c1) → `keymap = 16'h0001` the cycle after the first col-1 sample; `key_code = 4'h0`.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: groups the keypad matrix lines and the debounced key
// outputs of keypad_scanner.
//   row       : active-low matrix rows (driven by the keypad, read by scanner)
//   col       : one-cold column drive (driven by scanner)
//   keymap    : debounced key state, bit k = CHIP-8 key k held
//   key_event : one-cycle pulse on a new key press
//   key_code  : CHIP-8 value of the new press, held between events
// master = scanner side, slave = keypad / CPU side.
interface keypad_scanner_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] keymap;
  logic        key_event;
  logic [3:0]  key_code;

  modport master (
    input  row,
    output col,
    output keymap,
    output key_event,
    output key_code
  );

  modport slave (
    output row,
    input  col,
    input  keymap,
    input  key_event,
    input  key_code
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 hex keypad one column at a time, samples the
// active-low rows through a two-flop synchronizer and debounces each key
// independently.
//   fpga_clk : the only clock
//   rst_in   : asynchronous active-low reset
//   kp       : keypad_scanner_if.master (row in; col, keymap, key_event,
//              key_code out, all registered)
// SCAN_DIV       : cycles each column is driven before it is sampled (>= 4)
// DEBOUNCE_SCANS : consecutive disagreeing samples needed to flip a key (>= 1)
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 1024,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic             fpga_clk,
  input  logic             rst_in,
  keypad_scanner_if.master kp
);

  localparam int unsigned      DC_W     = $clog2(SCAN_DIV);
  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_SCANS) + 1;
  localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  // CHIP-8 value of the key at matrix position (row r, column c).
  function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0:    k = 4'h1;
      4'h1:    k = 4'h2;
      4'h2:    k = 4'h3;
      4'h3:    k = 4'hC;
      4'h4:    k = 4'h4;
      4'h5:    k = 4'h5;
      4'h6:    k = 4'h6;
      4'h7:    k = 4'hD;
      4'h8:    k = 4'h7;
      4'h9:    k = 4'h8;
      4'hA:    k = 4'h9;
      4'hB:    k = 4'hE;
      4'hC:    k = 4'hA;
      4'hD:    k = 4'h0;
      4'hE:    k = 4'hB;
      default: k = 4'hF;
    endcase
    return k;
  endfunction

  logic [3:0]       row_meta_q, row_meta_d;
  logic [3:0]       row_s_q,    row_s_d;
  logic [DC_W-1:0]  dc_q,       dc_d;
  logic [1:0]       c_q,        c_d;
  logic [3:0]       col_q,      col_d;
  logic [15:0]      keymap_q,   keymap_d;
  logic             key_event_q, key_event_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [CNT_W-1:0] cnt_q [16];
  logic [CNT_W-1:0] cnt_d [16];

  always_comb begin
    logic [3:0] k;
    logic       raw;
    logic       found;
    logic [3:0] best;

    row_meta_d  = kp.row;
    row_s_d     = row_meta_q;
    dc_d        = dc_q + 1'b1;
    c_d         = c_q;
    col_d       = col_q;
    keymap_d    = keymap_q;
    cnt_d       = cnt_q;
    key_event_d = 1'b0;
    key_code_d  = key_code_q;
    k           = '0;
    raw         = 1'b0;
    found       = 1'b0;
    best        = '1;

    if (dc_q == DC_LAST) begin
      dc_d  = '0;
      c_d   = c_q + 2'd1;
      col_d = ~(4'b0001 << c_d);
      // Only the four keys on the driven column are updated; the lowest
      // CHIP-8 value among fresh presses wins the event.
      for (int unsigned r = 0; r < 4; r++) begin
        k   = key_at(2'(r), c_q);
        raw = ~row_s_q[r];
        if (raw == keymap_q[k]) begin
          cnt_d[k] = '0;
        end else if (cnt_q[k] == CNT_LAST) begin
          keymap_d[k] = raw;
          cnt_d[k]    = '0;
          if (raw && (!found || k < best)) begin
            found = 1'b1;
            best  = k;
          end
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
      if (found) begin
        key_event_d = 1'b1;
        key_code_d  = best;
      end
    end
  end

  always_ff @(posedge fpga_clk or negedge rst_in) begin
    if (!rst_in) begin
      row_meta_q  <= '1;
      row_s_q     <= '1;
      dc_q        <= '0;
      c_q         <= '0;
      col_q       <= 4'b1110;
      keymap_q    <= '0;
      key_event_q <= 1'b0;
      key_code_q  <= '0;
      cnt_q       <= '{default: '0};
    end else begin
      row_meta_q  <= row_meta_d;
      row_s_q     <= row_s_d;
      dc_q        <= dc_d;
      c_q         <= c_d;
      col_q       <= col_d;
      keymap_q    <= keymap_d;
      key_event_q <= key_event_d;
      key_code_q  <= key_code_d;
      cnt_q       <= cnt_d;
    end
  end

  assign kp.col       = col_q;
  assign kp.keymap    = keymap_q;
  assign kp.key_event = key_event_q;
  assign kp.key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV=4.
// u_dut0 uses DEBOUNCE_SCANS=3, u_dut1 uses DEBOUNCE_SCANS=1. A matrix model
// pulls a row low when a held key sits on the currently driven column.
// Edge numbering: ecnt = rising edges since reset release; column c is
// sampled at edges e with e % 16 == 4*(c+1) (mod 16).
module tb_keypad_scanner;

  localparam logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hC,
                                      4'h4, 4'h5, 4'h6, 4'hD,
                                      4'h7, 4'h8, 4'h9, 4'hE,
                                      4'hA, 4'h0, 4'hB, 4'hF};

  logic        clk = 1'b0;
  logic        rst0_n, rst1_n;
  logic [15:0] pressed0, pressed1;
  int          ecnt;
  int          ev0, ev1;
  int          n_checks = 0;
  int          n_pass   = 0;

  keypad_scanner_if kp0 ();
  keypad_scanner_if kp1 ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) u_dut0 (
    .fpga_clk (clk),
    .rst_in   (rst0_n),
    .kp       (kp0.master)
  );

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(1)) u_dut1 (
    .fpga_clk (clk),
    .rst_in   (rst1_n),
    .kp       (kp1.master)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rows_for(input logic [15:0] p, input logic [3:0] col);
    logic [3:0] rr;
    rr = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && p[KMAP[r*4+c]]) rr[r] = 1'b0;
    return rr;
  endfunction

  assign kp0.row = rows_for(pressed0, kp0.col);
  assign kp1.row = rows_for(pressed1, kp1.col);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ecnt);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    ecnt++;
    if (kp0.key_event) ev0++;
    if (kp1.key_event) ev1++;
  endtask

  task automatic run_to(input int target);
    while (ecnt < target) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] one;
    logic [3:0] exp_col;
    one      = 4'b0001;
    rst0_n   = 1'b0;
    rst1_n   = 1'b0;
    pressed0 = '0;
    pressed1 = '0;
    ecnt     = 0;
    ev0      = 0;
    ev1      = 0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_col", 32'(kp0.col), 32'h0E);
    check("rst_keymap", 32'(kp0.keymap), 32'h0);
    check("rst_event", 32'(kp0.key_event), 32'h0);
    check("rst_code", 32'(kp0.key_code), 32'h0);
    rst0_n = 1'b1;
    ecnt   = 0;

    // 1: idle scan, col rotation every 4 cycles
    check("t1_col_e0", 32'(kp0.col), 32'h0E);
    for (int i = 0; i < 100; i++) begin
      step();
      exp_col = ~(one << ((ecnt / 4) % 4));
      check("t1_col", 32'(kp0.col), 32'(exp_col));
    end
    check("t1_keymap", 32'(kp0.keymap), 32'h0);
    check("t1_events", 32'(ev0), 32'd0);

    // 2: key 6 press (col-2 samples 108,124,140), release (156,172,188)
    ev0 = 0;
    pressed0[6] = 1'b1;
    run_to(139);
    check("t2_not_yet", 32'(kp0.keymap), 32'h0);
    run_to(140);
    check("t2_keymap", 32'(kp0.keymap), 32'h0040);
    check("t2_event", 32'(kp0.key_event), 32'h1);
    check("t2_code", 32'(kp0.key_code), 32'h6);
    run_to(141);
    check("t2_event_len", 32'(kp0.key_event), 32'h0);
    pressed0[6] = 1'b0;
    run_to(187);
    check("t2_rel_not_yet", 32'(kp0.keymap), 32'h0040);
    run_to(188);
    check("t2_rel_keymap", 32'(kp0.keymap), 32'h0);
    check("t2_code_hold", 32'(kp0.key_code), 32'h6);
    check("t2_events", 32'(ev0), 32'd1);

    // 3: bounce: pressed at 204,220, released at 236, pressed 252,268,284
    ev0 = 0;
    run_to(189);
    pressed0[6] = 1'b1;
    run_to(221);
    pressed0[6] = 1'b0;
    run_to(237);
    pressed0[6] = 1'b1;
    run_to(268);
    check("t3_bounce_hold", 32'(kp0.keymap), 32'h0);
    run_to(283);
    check("t3_not_yet", 32'(kp0.keymap), 32'h0);
    run_to(284);
    check("t3_keymap", 32'(kp0.keymap), 32'h0040);
    run_to(285);
    check("t3_events", 32'(ev0), 32'd1);
    pressed0[6] = 1'b0;
    run_to(333);
    check("t3_rel_keymap", 32'(kp0.keymap), 32'h0);

    // 4: A and 7 together (col-0 samples 340,356,372)
    ev0 = 0;
    pressed0[4'hA] = 1'b1;
    pressed0[4'h7] = 1'b1;
    run_to(372);
    check("t4_keymap", 32'(kp0.keymap), 32'h0480);
    check("t4_event", 32'(kp0.key_event), 32'h1);
    check("t4_code", 32'(kp0.key_code), 32'h7);
    run_to(373);
    check("t4_events", 32'(ev0), 32'd1);
    // swap to F: F appears at 416, A/7 clear at 420
    pressed0[4'hA] = 1'b0;
    pressed0[4'h7] = 1'b0;
    pressed0[4'hF] = 1'b1;
    run_to(421);
    check("t4_f_only", 32'(kp0.keymap), 32'h8000);
    check("t4_f_code", 32'(kp0.key_code), 32'hF);

    // 5: reset mid-dwell with F held
    run_to(422);
    check("t5_pre_keymap", 32'(kp0.keymap), 32'h8000);
    rst0_n = 1'b0;
    #1;
    check("t5_rst_keymap", 32'(kp0.keymap), 32'h0);
    check("t5_rst_col", 32'(kp0.col), 32'h0E);
    check("t5_rst_code", 32'(kp0.key_code), 32'h0);
    repeat (3) @(negedge clk);
    // 6 setup: key 0 held on dut1 before its release
    pressed1[4'h0] = 1'b1;
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    ecnt   = 0;
    ev0    = 0;
    ev1    = 0;

    // 6: DEBOUNCE_SCANS=1, key 0 on col 1 (first col-1 sample at edge 8)
    run_to(7);
    check("t6_not_yet", 32'(kp1.keymap), 32'h0);
    run_to(8);
    check("t6_keymap", 32'(kp1.keymap), 32'h0001);
    check("t6_event", 32'(kp1.key_event), 32'h1);
    check("t6_code", 32'(kp1.key_code), 32'h0);

    // 5 (cont.): F reappears on the third col-3 sample (16,32,48)
    run_to(47);
    check("t5_not_yet", 32'(kp0.keymap), 32'h0);
    run_to(48);
    check("t5_keymap", 32'(kp0.keymap), 32'h8000);
    check("t5_event", 32'(kp0.key_event), 32'h1);
    check("t5_code", 32'(kp0.key_code), 32'hF);
    run_to(50);
    check("t5_events", 32'(ev0), 32'd1);
    check("t6_events", 32'(ev1), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
